// File: rtl/sequenciador_multdiv.sv
// sequenciador_multdiv: iterative unsigned MULTU/DIVU sequencer driving a shared external ALU
module sequenciador_multdiv #(
  parameter logic [2:0] CTRL_SOMA = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inicio,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ocupado,
  output logic        pronto,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero,
  output logic        ula_uso,
  output logic [2:0]  ula_controle,
  output logic [31:0] ula_srcA,
  output logic [31:0] ula_srcB,
  output logic        ula_addSub,
  input  logic [31:0] ula_saida
);
  typedef enum logic [1:0] {OCIOSO, CALC, FIM} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_hi, r_lo, r_md;
  logic [4:0]  r_cnt;
  logic        r_op, r_dz;
  logic [31:0] w_t;
  logic        w_calc, w_cm, w_cd, w_acc;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= OCIOSO;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      OCIOSO:  w_next = inicio ? ((op && b == '0) ? FIM : CALC) : OCIOSO;
      CALC:    w_next = (r_cnt == 5'd31) ? FIM : CALC;
      FIM:     w_next = OCIOSO;
      default: w_next = OCIOSO;
    endcase
  end
  assign w_calc       = (r_state == CALC);
  assign w_t          = {r_hi[30:0], r_lo[31]};
  assign ula_uso      = w_calc;
  assign ula_controle = CTRL_SOMA;
  assign ula_srcA     = w_calc ? (r_op ? w_t : r_hi) : '0;
  assign ula_srcB     = w_calc ? r_md : '0;
  assign ula_addSub   = w_calc & r_op;
  assign ocupado      = (r_state != OCIOSO);
  assign pronto       = (r_state == FIM);
  assign hi           = r_hi;
  assign lo           = r_lo;
  assign div_zero     = r_dz;
  // carry-out of the 32-bit ALU reconstructed from operand and result sign bits
  assign w_cm  = (r_hi[31] & r_md[31]) | ((r_hi[31] | r_md[31]) & ~ula_saida[31]);
  assign w_cd  = (w_t[31] & ~r_md[31]) | ((w_t[31] | ~r_md[31]) & ~ula_saida[31]);
  assign w_acc = r_hi[31] | w_cd;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_md  <= '0;
      r_cnt <= '0;
      r_op  <= 1'b0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        OCIOSO:
          if (inicio) begin
            r_op  <= op;
            r_cnt <= '0;
            if (op && b == '0) begin
              r_hi <= a;
              r_lo <= '1;
              r_dz <= 1'b1;
            end else begin
              r_hi <= '0;
              r_lo <= a;
              r_md <= b;
              r_dz <= 1'b0;
            end
          end
        CALC: begin
          r_cnt <= r_cnt + 5'd1;
          if (!r_op)
            {r_hi, r_lo} <= r_lo[0] ? {w_cm, ula_saida, r_lo[31:1]} : {1'b0, r_hi, r_lo[31:1]};
          else begin
            r_hi <= w_acc ? ula_saida : w_t;
            r_lo <= {r_lo[30:0], w_acc};
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sequenciador_multdiv.sv
// tb_sequenciador_multdiv: directed and random checks of the MULTU/DIVU sequencer against an arithmetic model
module tb_sequenciador_multdiv;
  logic        clk = 0, reset = 1, inicio = 0, op = 0;
  logic [31:0] a = 0, b = 0;
  logic        ocupado, pronto, div_zero, ula_uso, ula_addSub;
  logic [31:0] hi, lo, ula_srcA, ula_srcB, ula_saida;
  logic [2:0]  ula_controle;
  int checks = 0, errors = 0;

  sequenciador_multdiv dut (
    .clk(clk), .reset(reset), .inicio(inicio), .op(op), .a(a), .b(b),
    .ocupado(ocupado), .pronto(pronto), .hi(hi), .lo(lo), .div_zero(div_zero),
    .ula_uso(ula_uso), .ula_controle(ula_controle), .ula_srcA(ula_srcA),
    .ula_srcB(ula_srcB), .ula_addSub(ula_addSub), .ula_saida(ula_saida)
  );

  always #5 clk = ~clk;
  assign ula_saida = ula_addSub ? ula_srcA - ula_srcB : ula_srcA + ula_srcB;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    if (!o) p = {32'd0, x} * {32'd0, y};
    else if (y == 0) p = {x, 32'hFFFFFFFF};
    else p = {x % y, x / y};
    return p;
  endfunction

  task automatic wait_pronto(output int n, output int uso);
    n = 0;
    uso = 0;
    while (!pronto && n < 100) begin
      uso += int'(ula_uso);
      step();
      n++;
    end
  endtask

  task automatic run(input string tag, input logic o, input logic [31:0] x, input logic [31:0] y);
    int n, uso;
    logic [63:0] e;
    logic dz;
    e = model(o, x, y);
    dz = o && (y == 0);
    inicio = 1; op = o; a = x; b = y;
    step();
    inicio = 0; a = $urandom; b = $urandom;
    if (!dz) chk({tag, " addsub"}, {63'd0, ula_addSub}, {63'd0, o});
    wait_pronto(n, uso);
    chk({tag, " latency"}, n, dz ? 0 : 32);
    chk({tag, " uso"}, uso, dz ? 0 : 32);
    chk({tag, " hilo"}, {hi, lo}, e);
    chk({tag, " dz"}, {63'd0, div_zero}, {63'd0, dz});
    step();
    chk({tag, " pulse"}, {62'd0, pronto, ocupado}, 64'd0);
    repeat (3) step();
    chk({tag, " hold"}, {hi, lo}, e);
  endtask

  initial begin
    int n, uso;
    #1;
    chk("reset outs", {hi, lo}, 64'd0);
    chk("reset flags", {58'd0, ocupado, pronto, div_zero, ula_uso, ula_addSub, 1'b0},
        64'd0);
    chk("reset alu", {ula_srcA, ula_srcB}, 64'd0);
    chk("ctrl", {61'd0, ula_controle}, 64'd2);
    step();
    reset = 0;
    step();
    run("mul3x5", 0, 3, 5);
    run("mulmax", 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run("div100_7", 1, 100, 7);
    run("divmax_1", 1, 32'hFFFFFFFF, 1);
    run("div_m", 1, 32'h80000000, 32'hFFFFFFFF);
    run("div42_0", 1, 42, 0);
    run("mulclr", 0, 11, 13);

    inicio = 1; op = 0; a = 6; b = 7;
    step();
    inicio = 0;
    repeat (10) step();
    inicio = 1; op = 1; a = 100; b = 0;
    step();
    inicio = 0;
    chk("ign busy", {62'd0, ocupado, pronto}, 64'd2);
    wait_pronto(n, uso);
    chk("ign lat", n + 11, 32);
    chk("ign hilo", {hi, lo}, 64'd42);
    chk("ign dz", {63'd0, div_zero}, 64'd0);
    inicio = 1; op = 0; a = 9; b = 9;
    step();
    chk("fim ign", {63'd0, ocupado}, 64'd0);
    step();
    inicio = 0;
    chk("fim next", {63'd0, ula_uso}, 64'd1);
    wait_pronto(n, uso);
    chk("fim hilo", {hi, lo}, 64'd81);
    step();

    inicio = 1; op = 0; a = 123; b = 456;
    step();
    inicio = 0;
    repeat (15) step();
    #2 reset = 1;
    #1;
    chk("abort hilo", {hi, lo}, 64'd0);
    chk("abort flags", {59'd0, ocupado, pronto, div_zero, ula_uso, ula_addSub}, 64'd0);
    chk("abort alu", {ula_srcA, ula_srcB}, 64'd0);
    uso = 0;
    repeat (3) begin
      step();
      uso += int'(pronto) + int'(ocupado);
    end
    reset = 0;
    repeat (35) begin
      step();
      uso += int'(pronto) + int'(ocupado);
    end
    chk("abort quiet", uso, 0);
    run("mul2x2", 0, 2, 2);

    for (int i = 0; i < 20; i++) begin
      logic o;
      logic [31:0] x, y;
      o = 1'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 1000)));
      run($sformatf("rnd%0d", i), o, x, y);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
